// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: register offsets, CTRL/STATUS bit positions and FSM encoding for uart_tx_dev
package uart_tx_pkg;
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DATA   = 2'd2;
  localparam logic [1:0] REG_DIV    = 2'd3;
  localparam int CTRL_EN   = 0;
  localparam int CTRL_IE   = 1;
  localparam int ST_EMPTY  = 0;
  localparam int ST_FULL   = 1;
  localparam int ST_BUSY   = 2;
  localparam int ST_OVF    = 3;
  localparam int ST_CNT_LO = 4;
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_t;
endpackage

// File: rtl/uart_tx_dev_if.sv
// uart_tx_dev_if: bridge-side bus of the UART transmitter
//   Addr : word address (only [1:0] decoded)   WE : full-word write strobe
//   Din  : write data                          Dout : combinational read data
//   IRQ  : level interrupt request
interface uart_tx_dev_if;
  logic [29:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;
  modport master (output Addr, WE, Din, input Dout, IRQ);
  modport slave (input Addr, WE, Din, output Dout, IRQ);
endinterface

// File: rtl/tx_fifo.sv
// tx_fifo: 8-bit synchronous FIFO with asynchronous clear
//   clk, reset : clock, async active-high clear
//   push, din  : write strobe and byte (caller guarantees not full unless popping)
//   pop, dout  : read strobe and head byte (caller guarantees not empty)
//   full, empty, count : occupancy
module tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [7:0]             din,
  output logic [7:0]             dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp, rp;
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= (push & ~pop) ? count + 1'b1 : (pop & ~push) ? count - 1'b1 : count;
    end
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout  = mem[rp];
endmodule

// File: rtl/uart_tx_dev.sv
// uart_tx_dev: memory-mapped 8N1 UART transmitter with TX FIFO and level IRQ
//   clk, reset : clock, async active-high reset
//   bus        : bridge responder (Addr/WE/Din in, Dout/IRQ out)
//   tx         : serial line, idles high
module uart_tx_dev
  import uart_tx_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd433
) (
  input  logic          clk,
  input  logic          reset,
  uart_tx_dev_if.slave  bus,
  output logic          tx
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  tx_state_t     state, state_n;
  logic          en, ie, ovf, irq;
  logic [15:0]   div, div_l, tmr;
  logic [2:0]    idx;
  logic [7:0]    shift;
  logic [7:0]    f_dout;
  logic          f_full, f_empty;
  logic [CW-1:0] f_cnt;
  logic [31:0]   cnt32;
  logic [3:0]    cnt4;
  logic [1:0]    a;
  logic          wr_ctrl, wr_status, wr_data, wr_div;
  logic          push, pop, tick, busy;
  logic          unused_ok;
  assign a         = bus.Addr[1:0];
  assign wr_ctrl   = bus.WE & (a == REG_CTRL);
  assign wr_status = bus.WE & (a == REG_STATUS);
  assign wr_data   = bus.WE & (a == REG_DATA);
  assign wr_div    = bus.WE & (a == REG_DIV);
  assign unused_ok = ^{bus.Addr[29:2], bus.Din[31:16]};
  assign tick = tmr == '0;
  assign busy = state != S_IDLE;
  // a full FIFO still takes a byte when the head leaves in the same cycle
  assign push = wr_data & (~f_full | pop);
  tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (bus.Din[7:0]),
    .dout  (f_dout),
    .full  (f_full),
    .empty (f_empty),
    .count (f_cnt)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    unique case (state)
      S_IDLE: begin
        pop     = en & ~f_empty;
        state_n = pop ? S_START : S_IDLE;
      end
      S_START: state_n = tick ? S_DATA : S_START;
      S_DATA:  state_n = (tick && idx == 3'd7) ? S_STOP : S_DATA;
      S_STOP:  state_n = tick ? S_IDLE : S_STOP;
      default: state_n = S_IDLE;
    endcase
  end
  // the bit timer counts the latched divisor down to zero, so each bit lasts div_l+1 cycles
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      en    <= 1'b0;
      ie    <= 1'b0;
      ovf   <= 1'b0;
      irq   <= 1'b0;
      div   <= DIV_RESET;
      div_l <= DIV_RESET;
      tmr   <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      irq <= ie & f_empty & ~busy;
      if (wr_ctrl) begin
        en <= bus.Din[CTRL_EN];
        ie <= bus.Din[CTRL_IE];
      end
      if (wr_div) div <= bus.Din[15:0];
      if (wr_status) ovf <= 1'b0;
      else if (wr_data && !push) ovf <= 1'b1;
      if (pop) begin
        shift <= f_dout;
        div_l <= div;
        tmr   <= div;
        idx   <= '0;
      end else if (busy) begin
        tmr <= tick ? div_l : tmr - 1'b1;
        if (tick && state == S_DATA) begin
          shift <= shift >> 1;
          idx   <= idx + 1'b1;
        end
      end
    end
  assign tx    = (state == S_START) ? 1'b0 : (state == S_DATA) ? shift[0] : 1'b1;
  assign cnt32 = 32'(f_cnt);
  assign cnt4  = (cnt32 > 32'd15) ? 4'hF : cnt32[3:0];
  assign bus.IRQ  = irq;
  assign bus.Dout = (a == REG_CTRL)   ? {30'b0, ie, en} :
                    (a == REG_STATUS) ? {24'b0, cnt4, ovf, busy, f_full, f_empty} :
                    (a == REG_DIV)    ? {16'b0, div} : 32'b0;
endmodule
